lte_dl_path_gain_tdm: RTL and testbench
=======================================

// Module: lte_dl_path_gain_tdm
// PURPOSE
//  Per-antenna complex gain stage for the LTE DL data path, on a TDM stream of N_ANT antenna samples.
//  Multiplies each I/Q sample by the gain of its antenna slot, rounds, optionally saturates, and re-aligns the frame markers.
//  Gains are double-buffered and switch atomically on a frame header; the slot counter advances only on valid samples.
//  Sits between the DL framer and the CPRI/JESD mapper, at the same point as the fixed 8-antenna power stage.
// PARAMETERS
//  N_ANT  8   antenna slots per TDM cycle, 1..16, need not be a power of 2
//  DW     16  I and Q width, signed
//  GW     16  gain I and Q width, signed
//  FRAC   15  fractional bits of gain; output = (x*g) >>> FRAC
// PORTS
//  clk             in   1        single clock
//  asy_rst         in   1        reset, synchronous to clk, active-high (port name kept for path compatibility)
//  i_cfg_we        in   1        write i_cfg_gain into shadow table at i_cfg_addr
//  i_cfg_addr      in   AW       AW=max(1,$clog2(N_ANT)); addr>=N_ANT is ignored
//  i_cfg_gain      in   2*GW     {gain_I, gain_Q}
//  i_cfg_commit    in   1        arm shadow->active copy at next frame header
//  i_fram_hd       in   1        frame header, qualified by i_data_valid, marks slot 0
//  i_ant8_sel      in   1        sideband, delayed with data
//  i_data          in   2*DW     {I, Q}
//  i_data_valid    in   1        sample strobe
//  o_fram_hd       out  1        i_fram_hd delayed LAT
//  o_ant8_sel      out  1        i_ant8_sel delayed LAT
//  o_data          out  2*DW     {I, Q} scaled
//  o_data_valid    out  1        i_data_valid delayed LAT
//  o_commit_pend   out  1        commit armed, not yet applied
//  o_sat           out  1        this output sample was clipped (0 when DL_GAIN_SAT_EN is undefined)
// BEHAVIOUR
//  Reset: all outputs 0; slot counter 0; shadow and active tables all {2^FRAC-1, 0}; pending 0; delay lines cleared.
//  Latency LAT=4 cycles, fixed, one sample per cycle, no back-pressure:
//   S1 register sample, sideband, and active gain of current slot; S2 four products (DW+GW bits);
//   S3 re=II-QQ, im=IQ+QI (DW+GW+1 bits), add 2^(FRAC-1), >>>FRAC; S4 saturate or truncate to DW, register outputs.
//  Slot counter: on valid&fram_hd the sample uses slot 0 and the counter becomes 1; on other valid samples it uses
//   the counter and counter <= (cnt==N_ANT-1)?0:cnt+1; holds on invalid cycles. N_ANT=1: counter stays 0.
//  Invalid cycles still propagate through the pipe; o_data is don't-care but deterministic (last value held).
//  Shadow write takes effect the cycle after i_cfg_we. Commit sets pending.
//  On the first valid&fram_hd sample while pending: active<=shadow before that sample's gain lookup,
//   so the whole frame uses the new table; pending clears.
//  Same-cycle we+commit: the write is included in the commit. Write while pending: included.
//  Commit while pending: no effect. Commit on the same cycle as a frame header: applies at the next header.
//  Reset mid-frame: the pipe flushes to 0, and the counter restarts at 0 on the first header.
//  Gain {-2^(GW-1),0} times x=-2^(DW-1) overflows: handled by saturation or wrap, below.
// CONFIGURATION
//  `DL_GAIN_SAT_EN defined: S4 clamps to [-2^(DW-1), 2^(DW-1)-1] per component; o_sat=1 if either component clipped.
//  `DL_GAIN_SAT_EN undefined: S4 keeps the low DW bits (two's-complement wrap); o_sat tied 0; no clip logic.
// STRUCTURE
//  Package lte_dl_pkg: LAT constant, unity-gain constant, cplx_t typedef {signed I,Q}, round/shift helper function.
//  One sub-module lte_cplx_mult_rnd: S2..S4 datapath (products, sum, round, sat/wrap), parametrised by DW/GW/FRAC.
//  The top level holds the tables, slot counter, commit logic, and sideband delay lines.
// TESTING
//  Unity gain: defaults, data {16'h1234,16'hEDCC} -> same value 4 cycles later, fram_hd/ant8_sel aligned.
//  Slot walk: N_ANT=8, gain[k]={16'h4000,0} for k even, {0,16'h4000} for k odd; I=16'h2000,Q=0 ->
//   even slots {16'h1000,0}, odd slots {0,16'h1000}; valid gaps of 3 cycles do not shift slots.
//  Atomic commit: write gain[3]=0 and commit mid-frame -> current frame unchanged; next frame slot 3 outputs 0; o_commit_pend falls on the header.
//  Saturation: x={16'h8000,16'h8000}, g={16'h8000,0} with DL_GAIN_SAT_EN -> {16'h7FFF,16'h7FFF}, o_sat=1; without it -> wrapped value, o_sat=0.
//  Rounding: x=1, g={16'h4000,0} (0.5) -> 1; x=-1 -> 0 (round-half-up).
//  N_ANT=3 wrap plus early header: header after slot 1 restarts at slot 0; reset mid-frame -> outputs 0 the next cycle.

Source files
------------

// File: rtl/lte_dl_path_gain_tdm_pkg.sv
// rtl/lte_dl_path_gain_tdm_pkg.sv - shared latency, types and rounding helper for the DL per-antenna gain stage
package lte_dl_pkg;

   localparam int LAT = 4;

   typedef struct packed {
      logic signed [15:0] i;
      logic signed [15:0] q;
   } cplx_t;

   // Largest representable gain just below 1.0 for a given number of fractional bits.
   function automatic logic [63:0] unity_gain(input int frac);
      return (64'd1 << frac) - 64'd1;
   endfunction

   // Round half up, then arithmetic shift right by frac.
   function automatic logic signed [63:0] rnd_shr(input logic signed [63:0] v, input int frac);
      logic signed [63:0] half;
      half = (frac > 0) ? (64'sd1 <<< (frac - 1)) : 64'sd0;
      return (v + half) >>> frac;
   endfunction

endpackage

// File: rtl/lte_dl_path_gain_tdm_if.sv
// rtl/lte_dl_path_gain_tdm_if.sv - config and TDM sample bus of the DL gain stage
interface lte_dl_path_gain_tdm_if #(
   parameter int N_ANT = 8,
   parameter int DW    = 16,
   parameter int GW    = 16
) ();
   localparam int AW = (N_ANT > 1) ? $clog2(N_ANT) : 1;

   logic            i_cfg_we;
   logic [AW-1:0]   i_cfg_addr;
   logic [2*GW-1:0] i_cfg_gain;
   logic            i_cfg_commit;
   logic            i_fram_hd;
   logic            i_ant8_sel;
   logic [2*DW-1:0] i_data;
   logic            i_data_valid;
   logic            o_fram_hd;
   logic            o_ant8_sel;
   logic [2*DW-1:0] o_data;
   logic            o_data_valid;
   logic            o_commit_pend;
   logic            o_sat;

   modport master (
      output i_cfg_we, i_cfg_addr, i_cfg_gain, i_cfg_commit,
      output i_fram_hd, i_ant8_sel, i_data, i_data_valid,
      input  o_fram_hd, o_ant8_sel, o_data, o_data_valid, o_commit_pend, o_sat
   );

   modport slave (
      input  i_cfg_we, i_cfg_addr, i_cfg_gain, i_cfg_commit,
      input  i_fram_hd, i_ant8_sel, i_data, i_data_valid,
      output o_fram_hd, o_ant8_sel, o_data, o_data_valid, o_commit_pend, o_sat
   );

endinterface

// File: rtl/lte_dl_path_gain_tdm_cplx_mult_rnd.sv
// rtl/lte_dl_path_gain_tdm_cplx_mult_rnd.sv - S2..S4 complex multiply, round-half-up, clamp or wrap
// Define DL_GAIN_SAT_EN to clamp each component to DW bits and flag clipping; otherwise results wrap.
module lte_cplx_mult_rnd
   import lte_dl_pkg::*;
#(
   parameter int DW   = 16,
   parameter int GW   = 16,
   parameter int FRAC = 15
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            vld_i,
   input  logic [2*DW-1:0] x_i,
   input  logic [2*GW-1:0] g_i,
   output logic [2*DW-1:0] y_o,
   output logic            sat_o
);
   localparam int PW = DW + GW;
   localparam int SW = DW + GW + 1;
`ifdef DL_GAIN_SAT_EN
   localparam int RW = SW;
   localparam logic signed [RW-1:0] MAXV = RW'((64'sd1 <<< (DW - 1)) - 64'sd1);
   localparam logic signed [RW-1:0] MINV = RW'(-(64'sd1 <<< (DW - 1)));
`else
   // Wrapping keeps only the low DW bits, so the rounded sum is stored at that width.
   localparam int RW = DW;
`endif

   logic signed [DW-1:0] xi, xq;
   logic signed [GW-1:0] gi, gq;
   logic signed [PW-1:0] pii_q, pqq_q, piq_q, pqi_q;
   logic signed [SW-1:0] sre, sim;
   logic signed [RW-1:0] re_d, im_d, re_q, im_q;
   logic [DW-1:0]        yi_d, yq_d, yi_q, yq_q;
   logic                 v2_q, v3_q;

   assign xi = x_i[2*DW-1:DW];
   assign xq = x_i[DW-1:0];
   assign gi = g_i[2*GW-1:GW];
   assign gq = g_i[GW-1:0];

   always_comb begin
      sre  = SW'(pii_q) - SW'(pqq_q);
      sim  = SW'(piq_q) + SW'(pqi_q);
      re_d = RW'(rnd_shr(64'(sre), FRAC));
      im_d = RW'(rnd_shr(64'(sim), FRAC));
   end

`ifdef DL_GAIN_SAT_EN
   logic sat_d, sat_q;

   always_comb begin
      yi_d  = re_q[DW-1:0];
      yq_d  = im_q[DW-1:0];
      sat_d = 1'b0;
      if (re_q > MAXV) begin
         yi_d  = MAXV[DW-1:0];
         sat_d = 1'b1;
      end else if (re_q < MINV) begin
         yi_d  = MINV[DW-1:0];
         sat_d = 1'b1;
      end
      if (im_q > MAXV) begin
         yq_d  = MAXV[DW-1:0];
         sat_d = 1'b1;
      end else if (im_q < MINV) begin
         yq_d  = MINV[DW-1:0];
         sat_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sat_q <= 1'b0;
      end else if (v3_q) begin
         sat_q <= sat_d;
      end
   end

   assign sat_o = sat_q;
`else
   always_comb begin
      yi_d = re_q;
      yq_d = im_q;
   end

   assign sat_o = 1'b0;
`endif

   // Each stage only loads on a valid sample so idle cycles hold the last result.
   always_ff @(posedge clk) begin
      if (rst) begin
         pii_q <= '0;
         pqq_q <= '0;
         piq_q <= '0;
         pqi_q <= '0;
         re_q  <= '0;
         im_q  <= '0;
         yi_q  <= '0;
         yq_q  <= '0;
         v2_q  <= 1'b0;
         v3_q  <= 1'b0;
      end else begin
         v2_q <= vld_i;
         v3_q <= v2_q;
         if (vld_i) begin
            pii_q <= PW'(xi) * PW'(gi);
            pqq_q <= PW'(xq) * PW'(gq);
            piq_q <= PW'(xi) * PW'(gq);
            pqi_q <= PW'(xq) * PW'(gi);
         end
         if (v2_q) begin
            re_q <= re_d;
            im_q <= im_d;
         end
         if (v3_q) begin
            yi_q <= yi_d;
            yq_q <= yq_d;
         end
      end
   end

   assign y_o = {yi_q, yq_q};

endmodule

// File: rtl/lte_dl_path_gain_tdm.sv
// rtl/lte_dl_path_gain_tdm.sv - per-antenna complex gain on a TDM DL stream with double-buffered gain tables
// Optional clip-and-flag output stage is enabled by defining DL_GAIN_SAT_EN.
module lte_dl_path_gain_tdm
   import lte_dl_pkg::*;
#(
   parameter int N_ANT = 8,
   parameter int DW    = 16,
   parameter int GW    = 16,
   parameter int FRAC  = 15
) (
   input logic                 clk,
   input logic                 asy_rst,
   lte_dl_path_gain_tdm_if.slave dl_io
);
   localparam int              AW       = (N_ANT > 1) ? $clog2(N_ANT) : 1;
   localparam logic [GW-1:0]   UNITY_I  = GW'(unity_gain(FRAC));
   localparam logic [2*GW-1:0] GAIN_ONE = {UNITY_I, {GW{1'b0}}};

   logic [2*GW-1:0] shadow_q [N_ANT];
   logic [2*GW-1:0] active_q [N_ANT];
   logic [AW-1:0]   cnt_q, cnt_d;
   logic            pend_q, pend_d;
   logic            hd_v, apply;
   logic [AW-1:0]   slot;
   logic [2*GW-1:0] gain_sel;
   logic [2*DW-1:0] x1_q;
   logic [2*GW-1:0] g1_q;
   logic [2:0]      side_q [LAT];

   always_comb begin
      hd_v  = dl_io.i_data_valid & dl_io.i_fram_hd;
      apply = hd_v & pend_q;
      slot  = hd_v ? '0 : cnt_q;
      // A header applying a commit must already see the new table for its own slot 0.
      gain_sel = apply ? shadow_q[slot] : active_q[slot];

      cnt_d = cnt_q;
      if (hd_v) begin
         cnt_d = (N_ANT == 1) ? '0 : AW'(1);
      end else if (dl_io.i_data_valid) begin
         cnt_d = (cnt_q == AW'(N_ANT - 1)) ? '0 : cnt_q + AW'(1);
      end

      pend_d = pend_q;
      if (apply) begin
         pend_d = 1'b0;
      end else if (dl_io.i_cfg_commit) begin
         pend_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (asy_rst) begin
         cnt_q  <= '0;
         pend_q <= 1'b0;
         x1_q   <= '0;
         g1_q   <= '0;
         for (int k = 0; k < N_ANT; k++) begin
            shadow_q[k] <= GAIN_ONE;
            active_q[k] <= GAIN_ONE;
         end
         for (int k = 0; k < LAT; k++) begin
            side_q[k] <= '0;
         end
      end else begin
         cnt_q  <= cnt_d;
         pend_q <= pend_d;
         if (dl_io.i_cfg_we && ({1'b0, dl_io.i_cfg_addr} < (AW + 1)'(N_ANT))) begin
            shadow_q[dl_io.i_cfg_addr] <= dl_io.i_cfg_gain;
         end
         if (apply) begin
            for (int k = 0; k < N_ANT; k++) begin
               active_q[k] <= shadow_q[k];
            end
         end
         if (dl_io.i_data_valid) begin
            x1_q <= dl_io.i_data;
            g1_q <= gain_sel;
         end
         side_q[0] <= {dl_io.i_data_valid, dl_io.i_fram_hd, dl_io.i_ant8_sel};
         for (int k = 1; k < LAT; k++) begin
            side_q[k] <= side_q[k-1];
         end
      end
   end

   lte_cplx_mult_rnd #(
      .DW   (DW),
      .GW   (GW),
      .FRAC (FRAC)
   ) u_mult (
      .clk   (clk),
      .rst   (asy_rst),
      .vld_i (side_q[0][2]),
      .x_i   (x1_q),
      .g_i   (g1_q),
      .y_o   (dl_io.o_data),
      .sat_o (dl_io.o_sat)
   );

   assign dl_io.o_data_valid  = side_q[LAT-1][2];
   assign dl_io.o_fram_hd     = side_q[LAT-1][1];
   assign dl_io.o_ant8_sel    = side_q[LAT-1][0];
   assign dl_io.o_commit_pend = pend_q;

endmodule

// File: tb/tb_lte_dl_path_gain_tdm.sv
// tb/tb_lte_dl_path_gain_tdm.sv - scoreboard bench for the DL gain stage (N_ANT=8 and N_ANT=3 instances)
module tb_lte_dl_path_gain_tdm;

   logic clk = 1'b0;
   logic rst8, rst3;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   lte_dl_path_gain_tdm_if #(.N_ANT(8), .DW(16), .GW(16)) a ();
   lte_dl_path_gain_tdm_if #(.N_ANT(3), .DW(16), .GW(16)) b ();

   lte_dl_path_gain_tdm #(.N_ANT(8), .DW(16), .GW(16), .FRAC(15)) dut8 (
      .clk(clk), .asy_rst(rst8), .dl_io(a));
   lte_dl_path_gain_tdm #(.N_ANT(3), .DW(16), .GW(16), .FRAC(15)) dut3 (
      .clk(clk), .asy_rst(rst3), .dl_io(b));

   typedef struct {
      logic [31:0] d;
      logic        hd;
      logic        a8;
      logic        sat;
      int          cyc;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];

`ifdef DL_GAIN_SAT_EN
   localparam logic [31:0] SAT_D = 32'h7FFF7FFF;
   localparam logic        SAT_F = 1'b1;
`else
   localparam logic [31:0] SAT_D = 32'h80008000;
   localparam logic        SAT_F = 1'b0;
`endif

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
      total++;
      if (got !== req) begin
         bad++;
         $display("FAIL %s got=%h required=%h", name, got, req);
      end
   endtask

   task automatic check_out(input int inst, input logic [31:0] d, input logic hd,
                            input logic a8, input logic sat);
      exp_t e;
      total++;
      if ((inst == 0 && qa.size() == 0) || (inst == 1 && qb.size() == 0)) begin
         bad++;
         $display("FAIL unexpected_out inst=%0d got=%h required=no output", inst, d);
         return;
      end
      if (inst == 0) e = qa.pop_front();
      else           e = qb.pop_front();
      if (d !== e.d || hd !== e.hd || a8 !== e.a8 || sat !== e.sat || cyc != e.cyc) begin
         bad++;
         $display("FAIL out inst=%0d got d=%h hd=%b a8=%b sat=%b cyc=%0d required d=%h hd=%b a8=%b sat=%b cyc=%0d",
                  inst, d, hd, a8, sat, cyc, e.d, e.hd, e.a8, e.sat, e.cyc);
      end
   endtask

   always @(negedge clk) begin
      if (a.o_data_valid) check_out(0, a.o_data, a.o_fram_hd, a.o_ant8_sel, a.o_sat);
      if (b.o_data_valid) check_out(1, b.o_data, b.o_fram_hd, b.o_ant8_sel, b.o_sat);
   end

   task automatic send(input int inst, input logic [31:0] d, input logic hd, input logic a8,
                       input logic [31:0] ed, input logic esat);
      @(posedge clk); #1;
      if (inst == 0) begin
         a.i_data = d; a.i_data_valid = 1'b1; a.i_fram_hd = hd; a.i_ant8_sel = a8;
         qa.push_back('{ed, hd, a8, esat, cyc + 4});
      end else begin
         b.i_data = d; b.i_data_valid = 1'b1; b.i_fram_hd = hd; b.i_ant8_sel = a8;
         qb.push_back('{ed, hd, a8, esat, cyc + 4});
      end
   endtask

   task automatic idle(input int inst, input int n);
      @(posedge clk); #1;
      if (inst == 0) begin
         a.i_data_valid = 1'b0; a.i_fram_hd = 1'b0; a.i_ant8_sel = 1'b0;
      end else begin
         b.i_data_valid = 1'b0; b.i_fram_hd = 1'b0; b.i_ant8_sel = 1'b0;
      end
      repeat (n - 1) @(posedge clk);
   endtask

   task automatic cfg(input int inst, input logic we, input int addr, input logic [31:0] g,
                      input logic commit);
      @(posedge clk); #1;
      if (inst == 0) begin
         a.i_cfg_we = we; a.i_cfg_addr = 3'(addr); a.i_cfg_gain = g; a.i_cfg_commit = commit;
      end else begin
         b.i_cfg_we = we; b.i_cfg_addr = 2'(addr); b.i_cfg_gain = g; b.i_cfg_commit = commit;
      end
      @(posedge clk); #1;
      a.i_cfg_we = 1'b0; a.i_cfg_commit = 1'b0;
      b.i_cfg_we = 1'b0; b.i_cfg_commit = 1'b0;
   endtask

   initial begin
      rst8 = 1'b1; rst3 = 1'b1;
      a.i_cfg_we = 0; a.i_cfg_addr = '0; a.i_cfg_gain = '0; a.i_cfg_commit = 0;
      a.i_fram_hd = 0; a.i_ant8_sel = 0; a.i_data = '0; a.i_data_valid = 0;
      b.i_cfg_we = 0; b.i_cfg_addr = '0; b.i_cfg_gain = '0; b.i_cfg_commit = 0;
      b.i_fram_hd = 0; b.i_ant8_sel = 0; b.i_data = '0; b.i_data_valid = 0;
      repeat (3) @(posedge clk);
      #1;
      rst8 = 1'b0; rst3 = 1'b0;

      chk("rst_data", a.o_data, 32'h0);
      chk("rst_flags", 32'({a.o_data_valid, a.o_fram_hd, a.o_ant8_sel, a.o_sat}), 32'h0);
      chk("rst_pend", 32'(a.o_commit_pend), 32'h0);
      chk("rst3_data", b.o_data, 32'h0);

      // Unity defaults: 0x7FFF gain with rounding reproduces ordinary values exactly.
      send(0, 32'h1234EDCC, 1'b1, 1'b1, 32'h1234EDCC, 1'b0);
      send(0, 32'h7FFF8000, 1'b0, 1'b0, 32'h7FFE8001, 1'b0);
      idle(0, 2);

      // Slot walk: half gain on I for even slots, rotate into Q for odd slots.
      for (int k = 0; k < 8; k++)
         cfg(0, 1'b1, k, (k % 2 == 0) ? 32'h40000000 : 32'h00004000, k == 7);
      chk("pend_after_commit", 32'(a.o_commit_pend), 32'h1);
      for (int k = 0; k < 8; k++) begin
         send(0, 32'h20000000, k == 0, k[0], (k % 2 == 0) ? 32'h10000000 : 32'h00001000, 1'b0);
         if (k == 1) chk("pend_clear_on_hd", 32'(a.o_commit_pend), 32'h0);
         if (k % 3 == 1) idle(0, 3);
      end

      // Rounding half up: +0.5 -> 1, -0.5 -> 0.
      send(0, 32'h00010001, 1'b1, 1'b0, 32'h00010001, 1'b0);
      send(0, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b0);
      send(0, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h00000000, 1'b0);
      idle(0, 1);

      // Mid-frame write+commit must not disturb the rest of this frame.
      cfg(0, 1'b1, 3, 32'h00000000, 1'b1);
      chk("pend_mid_frame", 32'(a.o_commit_pend), 32'h1);
      for (int k = 3; k < 8; k++)
         send(0, 32'h20000000, 1'b0, k[0], (k % 2 == 0) ? 32'h10000000 : 32'h00001000, 1'b0);
      chk("pend_before_hd", 32'(a.o_commit_pend), 32'h1);
      for (int k = 0; k < 4; k++) begin
         send(0, 32'h20000000, k == 0, 1'b1,
              (k == 3) ? 32'h00000000 : ((k % 2 == 0) ? 32'h10000000 : 32'h00001000), 1'b0);
         if (k == 1) chk("pend_fall_on_hd", 32'(a.o_commit_pend), 32'h0);
      end
      idle(0, 1);

      // Full-scale negative times -1.0 gain overflows.
      cfg(0, 1'b1, 4, 32'h80000000, 1'b1);
      send(0, 32'h20000000, 1'b1, 1'b0, 32'h10000000, 1'b0);
      send(0, 32'h20000000, 1'b0, 1'b0, 32'h00001000, 1'b0);
      send(0, 32'h20000000, 1'b0, 1'b0, 32'h10000000, 1'b0);
      send(0, 32'h20000000, 1'b0, 1'b0, 32'h00000000, 1'b0);
      send(0, 32'h80008000, 1'b0, 1'b1, SAT_D, SAT_F);
      idle(0, 1);

      // N_ANT=3: distinct gain per slot, early header and wrap.
      cfg(1, 1'b1, 0, 32'h40000000, 1'b0);
      cfg(1, 1'b1, 1, 32'h00004000, 1'b0);
      cfg(1, 1'b1, 3, 32'h00000000, 1'b0);
      cfg(1, 1'b1, 2, 32'h20000000, 1'b1);
      send(1, 32'h20000000, 1'b1, 1'b0, 32'h10000000, 1'b0);
      send(1, 32'h20000000, 1'b0, 1'b1, 32'h00001000, 1'b0);
      send(1, 32'h20000000, 1'b1, 1'b0, 32'h10000000, 1'b0);
      send(1, 32'h20000000, 1'b0, 1'b1, 32'h00001000, 1'b0);
      send(1, 32'h20000000, 1'b0, 1'b0, 32'h08000000, 1'b0);
      send(1, 32'h20000000, 1'b0, 1'b1, 32'h10000000, 1'b0);
      send(1, 32'h20000000, 1'b0, 1'b0, 32'h00001000, 1'b0);
      idle(1, 6);

      // Reset with samples in flight: they are dropped and outputs clear at once.
      send(1, 32'h20000000, 1'b0, 1'b1, 32'h08000000, 1'b0);
      send(1, 32'h20000000, 1'b0, 1'b1, 32'h10000000, 1'b0);
      rst3 = 1'b1;
      b.i_data_valid = 1'b0;
      qb.delete();
      @(posedge clk); #1;
      chk("midrst_data", b.o_data, 32'h0);
      chk("midrst_flags", 32'({b.o_data_valid, b.o_fram_hd, b.o_ant8_sel, b.o_sat, b.o_commit_pend}), 32'h0);
      @(posedge clk); #1;
      rst3 = 1'b0;
      send(1, 32'h20000000, 1'b0, 1'b0, 32'h20000000, 1'b0);
      send(1, 32'h20000000, 1'b1, 1'b1, 32'h20000000, 1'b0);
      idle(1, 1);

      for (int i = 0; i < 60 && (qa.size() != 0 || qb.size() != 0); i++) @(posedge clk);
      total++;
      if (qa.size() != 0 || qb.size() != 0) begin
         bad++;
         $display("FAIL drain got=%0d/%0d pending required=0/0", qa.size(), qb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
